// File: rtl/busca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : busca_pkg
//  Description : Shared constants and types for the instruction fetch unit:
//                PC increment, prefetch buffer depth, buffer entry layout
//                and buffer occupancy states.
//  Revision    : 1.0 - initial release
// ============================================================================
package busca_pkg;

  localparam int PC_INC     = 4;   // bytes per instruction word
  localparam int FILA_DEPTH = 2;   // prefetch buffer entries

  localparam int ENTRY_PC_W    = 32;
  localparam int ENTRY_INSTR_W = 32;

  // One prefetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } entry_t;

  // Prefetch buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ocup_t;

endpackage : busca_pkg
`default_nettype wire

// File: rtl/fila_busca.sv
`default_nettype none
// ============================================================================
//  Module      : fila_busca
//  Description : Two-entry prefetch FIFO holding {pc, instr} pairs toward
//                decode. Flush empties the buffer; the head registers keep
//                their last value while empty.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          : clock, rising edge
//    rst_n        : synchronous active-low reset
//    i_push       : enqueue {i_pc, i_instr} (never asserted when FULL w/o pop)
//    i_pop        : head consumed this cycle
//    i_flush      : drop all entries (wins over push/pop)
//    i_pc/i_instr : entry to enqueue
//    o_valid      : head valid (registered)
//    o_pc/o_instr : head entry
//    o_state      : occupancy state
// ============================================================================
module fila_busca
  import busca_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output ocup_t              o_state
);

  ocup_t              r_state;
  logic               r_valid;
  logic [PC_W-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_head_instr;
  logic [PC_W-1:0]    r_tail_pc;
  logic [INSTR_W-1:0] r_tail_instr;

  // Head is always slot 0; the second entry shifts into the head on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_valid      <= 1'b0;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else if (i_flush) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head_pc    <= i_pc;
            r_head_instr <= i_instr;
            r_state      <= ONE;
            r_valid      <= 1'b1;
          end
        end
        ONE: begin
          case ({i_push, i_pop})
            2'b10: begin
              r_tail_pc    <= i_pc;
              r_tail_instr <= i_instr;
              r_state      <= FULL;
            end
            2'b01: begin
              r_state <= EMPTY;
              r_valid <= 1'b0;
            end
            2'b11: begin
              r_head_pc    <= i_pc;
              r_head_instr <= i_instr;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (i_pop) begin
            r_head_pc    <= r_tail_pc;
            r_head_instr <= r_tail_instr;
            if (i_push) begin
              r_tail_pc    <= i_pc;
              r_tail_instr <= i_instr;
            end else begin
              r_state <= ONE;
            end
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_head_pc;
  assign o_instr = r_head_instr;
  assign o_state = r_state;

endmodule : fila_busca
`default_nettype wire

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
//  Module      : busca_instrucao
//  Description : Instruction fetch unit. Holds the fetch PC, addresses the
//                instruction memory, and queues fetched words with their PC
//                in a 2-entry prefetch buffer. Execute-stage redirects flush
//                the buffer and reload the fetch PC.
//  Config macro: BUSCA_ALIGN_CHECK_EN - when defined, a misaligned redirect
//                raises the sticky misalign output and halts fetch; when
//                undefined, redirect targets are forced word-aligned and the
//                misalign port does not exist.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n      : clock, synchronous active-low reset
//    endr            : memory word address = fetch_pc[ENDR_W+1:2]
//    dout            : memory read data (combinational from endr)
//    redirect        : taken branch/jump this cycle
//    redirect_pc     : redirect target byte address
//    instr_valid     : buffer head valid
//    instr, instr_pc : buffer head instruction and its byte PC
//    instr_ready     : decode accepts head this cycle
//    misalign        : sticky misaligned-redirect flag (macro only)
// ============================================================================
module busca_instrucao
  import busca_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ENDR_W   = 5,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(4)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ENDR_W-1:0]  endr,
  input  logic [INSTR_W-1:0] dout,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
`ifdef BUSCA_ALIGN_CHECK_EN
  ,
  output logic               misalign
`endif
);

  logic [PC_W-1:0] r_fetch_pc;
  logic            w_pop;
  logic            w_push;
  logic            w_halt;
  ocup_t           w_state;

`ifdef BUSCA_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_halt   = r_misalign;
  assign misalign = r_misalign;
`else
  assign w_halt = 1'b0;
`endif

  assign endr   = r_fetch_pc[ENDR_W+1:2];
  assign w_pop  = instr_valid && instr_ready;
  // A slot freed by this cycle's pop can be refilled in the same cycle.
  assign w_push = !redirect && !w_halt && ((w_state != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
`ifdef BUSCA_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else if (redirect) begin
`ifdef BUSCA_ALIGN_CHECK_EN
      r_fetch_pc <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
`else
      r_fetch_pc <= redirect_pc & ~PC_W'(3);
`endif
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_W'(PC_INC);
    end
  end

  fila_busca #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fila (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_pc    (r_fetch_pc),
    .i_instr (dout),
    .o_valid (instr_valid),
    .o_pc    (instr_pc),
    .o_instr (instr),
    .o_state (w_state)
  );

endmodule : busca_instrucao
`default_nettype wire
